// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared period counter feeding NUM_CH duty
// comparators. Period/duty updates are double-buffered and switch over only at
// a period boundary so outputs never show runt pulses.
// Optional build macro: PWM_CENTER_ALIGNED_EN adds center_i for up/down
// (center-aligned) counting.
module pwm_multi_channel #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4,
    parameter int DUTY_W = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic [CNT_W-1:0]         period_i,
    input  logic [NUM_CH*DUTY_W-1:0] duty_i,
    input  logic                     load_i,
`ifdef PWM_CENTER_ALIGNED_EN
    input  logic                     center_i,
`endif
    output logic                     load_ack_o,
    output logic                     period_tick_o,
    output logic [NUM_CH-1:0]        pwm_o,
    output logic                     busy_o
);

    localparam int TH_W   = CNT_W + 1;
    localparam int PROD_W = CNT_W + 1 + DUTY_W;

    typedef enum logic {IDLE, RUN} state_t;

    // Threshold = ((P+1) * duty) >> DUTY_W; a full-scale duty saturates so
    // the comparator is always true and the channel stays high.
    function automatic logic [TH_W-1:0] calc_th(input logic [CNT_W-1:0]  p,
                                                 input logic [DUTY_W-1:0] d);
        logic [PROD_W-1:0] prod;
        logic [TH_W-1:0]   th;
        prod = PROD_W'({1'b0, p} + TH_W'(1)) * PROD_W'(d);
        th   = prod[PROD_W-1:DUTY_W];
        if (&d) begin
            th = '1;
        end
        return th;
    endfunction

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          period_act_q, period_act_d;
    logic [TH_W-1:0]           th_q [NUM_CH];
    logic [TH_W-1:0]           th_d [NUM_CH];
    logic [CNT_W-1:0]          period_pend_q, period_pend_d;
    logic [NUM_CH*DUTY_W-1:0]  duty_pend_q, duty_pend_d;
    logic                      pend_q, pend_d;
    logic                      ack_q, ack_d;
    logic                      tick_q, tick_d;
    logic [NUM_CH-1:0]         pwm_q, pwm_d;
    logic                      busy_q, busy_d;

    logic                      apply;
    logic [CNT_W-1:0]          src_period;
    logic [NUM_CH*DUTY_W-1:0]  src_duty;
    logic                      wrap;
    logic [CNT_W-1:0]          cnt_next;

`ifdef PWM_CENTER_ALIGNED_EN
    logic                      center_q, center_d;
    logic                      dir_q, dir_d;
    logic                      dir_next;
`endif

    // Next-state logic: counter sequencing, load buffering and output compare.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_act_d  = period_act_q;
        th_d          = th_q;
        period_pend_d = period_pend_q;
        duty_pend_d   = duty_pend_q;
        pend_d        = pend_q;
        ack_d         = 1'b0;
        tick_d        = 1'b0;
        pwm_d         = '0;
        apply         = 1'b0;
        src_period    = period_pend_q;
        src_duty      = duty_pend_q;
        wrap          = (cnt_q == period_act_q);
        cnt_next      = cnt_q + CNT_W'(1);
`ifdef PWM_CENTER_ALIGNED_EN
        center_d      = center_q;
        dir_d         = dir_q;
        dir_next      = dir_q;
        if (center_q) begin
            wrap = 1'b0;
            if (!dir_q) begin
                if (cnt_q == period_act_q) begin
                    if (period_act_q <= CNT_W'(1)) begin
                        wrap = 1'b1;
                    end else begin
                        cnt_next = period_act_q - CNT_W'(1);
                        dir_next = 1'b1;
                    end
                end
            end else begin
                if (cnt_q <= CNT_W'(1)) begin
                    wrap = 1'b1;
                end else begin
                    cnt_next = cnt_q - CNT_W'(1);
                end
            end
        end
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef PWM_CENTER_ALIGNED_EN
                dir_d    = 1'b0;
                center_d = center_i;
`endif
                if (load_i) begin
                    apply      = 1'b1;
                    src_period = period_i;
                    src_duty   = duty_i;
                    ack_d      = 1'b1;
                end
                if (En) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!En) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef PWM_CENTER_ALIGNED_EN
                    dir_d   = 1'b0;
`endif
                end else begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        pwm_d[k] = ({1'b0, cnt_q} < th_q[k]);
                    end
                    if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
                        dir_d    = 1'b0;
                        center_d = center_i;
`endif
                        if (pend_q) begin
                            apply  = 1'b1;
                            ack_d  = 1'b1;
                            pend_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_next;
`ifdef PWM_CENTER_ALIGNED_EN
                        dir_d = dir_next;
`endif
                    end
                end
                // A load landing on the boundary cycle queues behind the
                // pending data that is being applied right now.
                if (load_i) begin
                    period_pend_d = period_i;
                    duty_pend_d   = duty_i;
                    pend_d        = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (apply) begin
            period_act_d = src_period;
            for (int k = 0; k < NUM_CH; k++) begin
                th_d[k] = calc_th(src_period, src_duty[k*DUTY_W +: DUTY_W]);
            end
        end

        busy_d = (state_d == RUN);
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            period_act_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                th_q[k] <= '0;
            end
            period_pend_q <= '0;
            duty_pend_q   <= '0;
            pend_q        <= 1'b0;
            ack_q         <= 1'b0;
            tick_q        <= 1'b0;
            pwm_q         <= '0;
            busy_q        <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            center_q      <= 1'b0;
            dir_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_act_q  <= period_act_d;
            th_q          <= th_d;
            period_pend_q <= period_pend_d;
            duty_pend_q   <= duty_pend_d;
            pend_q        <= pend_d;
            ack_q         <= ack_d;
            tick_q        <= tick_d;
            pwm_q         <= pwm_d;
            busy_q        <= busy_d;
`ifdef PWM_CENTER_ALIGNED_EN
            center_q      <= center_d;
            dir_q         <= dir_d;
`endif
        end
    end

    assign load_ack_o    = ack_q;
    assign period_tick_o = tick_q;
    assign pwm_o         = pwm_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel (default edge-aligned build).
// A cycle-level reference model pushes expected outputs into a queue as each
// stimulus is driven; they are popped and compared after the clock edge.
module tb_pwm_multi_channel;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        En;
    logic [15:0] period_i;
    logic [31:0] duty_i;
    logic        load_i;
    logic        load_ack_o;
    logic        period_tick_o;
    logic [3:0]  pwm_o;
    logic        busy_o;

    pwm_multi_channel #(.CNT_W(16), .NUM_CH(4), .DUTY_W(8)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .En            (En),
        .period_i      (period_i),
        .duty_i        (duty_i),
        .load_i        (load_i),
`ifdef PWM_CENTER_ALIGNED_EN
        .center_i      (1'b0),
`endif
        .load_ack_o    (load_ack_o),
        .period_tick_o (period_tick_o),
        .pwm_o         (pwm_o),
        .busy_o        (busy_o)
    );

    // Free-running clock.
    always #5 Clk = ~Clk;

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct packed {
        logic [3:0] pwm;
        logic       tick;
        logic       ack;
        logic       busy;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    int          cur_p = 0;
    logic [31:0] cur_d = '0;

    bit          m_run  = 0;
    int          m_cnt  = 0;
    int          m_p    = 0;
    int          m_th[4];
    bit          m_pend = 0;
    int          m_pp   = 0;
    logic [31:0] m_pduty = '0;

    logic [3:0]  obs_pwm;
    logic        obs_tick;
    logic        obs_ack;
    logic        obs_busy;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference threshold: high cycles per period for a given duty.
    function automatic int model_th(input int p, input logic [7:0] d);
        if (d == 8'hFF) return 32'h7FFF_FFFF;
        return ((p + 1) * int'(d)) / 256;
    endfunction

    // Advance the reference model by one clock and return expected outputs.
    task automatic modelStep(input bit rst, input bit en, input bit ld, output exp_t e);
        e = '0;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_p = 0; m_pend = 0; m_pp = 0; m_pduty = '0;
            for (int k = 0; k < 4; k++) m_th[k] = 0;
        end else if (!m_run) begin
            e.ack = ld;
            if (ld) begin
                m_p = cur_p;
                for (int k = 0; k < 4; k++) m_th[k] = model_th(cur_p, cur_d[k*8 +: 8]);
            end
            m_run  = en;
            e.busy = en;
            m_cnt  = 0;
        end else if (!en) begin
            m_run = 0;
            m_cnt = 0;
            if (ld) begin m_pend = 1; m_pp = cur_p; m_pduty = cur_d; end
        end else begin
            e.busy = 1;
            for (int k = 0; k < 4; k++) e.pwm[k] = (m_cnt < m_th[k]);
            if (m_cnt == m_p) begin
                e.tick = 1;
                m_cnt  = 0;
                if (m_pend) begin
                    e.ack  = 1;
                    m_pend = 0;
                    m_p    = m_pp;
                    for (int k = 0; k < 4; k++) m_th[k] = model_th(m_pp, m_pduty[k*8 +: 8]);
                end
            end else begin
                m_cnt++;
            end
            if (ld) begin m_pend = 1; m_pp = cur_p; m_pduty = cur_d; end
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, then compare.
    task automatic applyStimulus(input bit rst, input bit en, input bit ld);
        exp_t e;
        exp_t want;
        Rst      = rst;
        En       = en;
        load_i   = ld;
        period_i = 16'(cur_p);
        duty_i   = cur_d;
        modelStep(rst, en, ld, e);
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        want     = sb_q.pop_front();
        obs_pwm  = pwm_o;
        obs_tick = period_tick_o;
        obs_ack  = load_ack_o;
        obs_busy = busy_o;
        checkOutput("pwm",  32'(pwm_o),         32'(want.pwm));
        checkOutput("tick", 32'(period_tick_o), 32'(want.tick));
        checkOutput("ack",  32'(load_ack_o),    32'(want.ack));
        checkOutput("busy", 32'(busy_o),        32'(want.busy));
        load_i = 1'b0;
    endtask

    // Run until the model counter reaches a value (bounded).
    task automatic runToCnt(input int target);
        for (int i = 0; i < 100 && m_cnt != target; i++) applyStimulus(0, 1, 0);
        checkOutput("run_to_cnt", 32'(m_cnt), 32'(target));
    endtask

    // Wait for a load acknowledge, bounded; timeout counts as a failure.
    task automatic waitAck(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(0, 1, 0);
            if (obs_ack) seen = 1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    // Observe n running cycles, summing highs per channel, ticks and acks.
    task automatic window(input int n, output int hi[4], output int ticks, output int acks);
        for (int k = 0; k < 4; k++) hi[k] = 0;
        ticks = 0;
        acks  = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 1, 0);
            for (int k = 0; k < 4; k++) hi[k] += int'(obs_pwm[k]);
            ticks += int'(obs_tick);
            acks  += int'(obs_ack);
        end
    endtask

    int hi[4];
    int ticks;
    int acks;

    // Main stimulus sequence.
    initial begin
        Rst = 1'b1; En = 1'b0; load_i = 1'b0; period_i = '0; duty_i = '0;

        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("rst_pwm",  32'(pwm_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_ack",  32'(load_ack_o), 32'd0);

        // Basic duties at P=9.
        cur_p = 9; cur_d = 32'hFF80_4000;
        applyStimulus(0, 0, 1);
        checkOutput("idle_load_ack", 32'(obs_ack), 32'd1);
        applyStimulus(0, 1, 0);
        checkOutput("busy_on", 32'(obs_busy), 32'd1);
        repeat (5) applyStimulus(0, 1, 0);
        window(10, hi, ticks, acks);
        checkOutput("p9_ch0", hi[0], 0);
        checkOutput("p9_ch1", hi[1], 2);
        checkOutput("p9_ch2", hi[2], 5);
        checkOutput("p9_ch3", hi[3], 10);
        checkOutput("p9_ticks", ticks, 1);

        // Mid-period change to P=19, applied at the next wrap.
        runToCnt(4);
        cur_p = 19; cur_d = 32'hFF80_4000;
        applyStimulus(0, 1, 1);
        waitAck("p19_ack", 30);
        checkOutput("p19_ack_on_wrap", 32'(obs_tick), 32'd1);
        window(20, hi, ticks, acks);
        checkOutput("p19_ch2", hi[2], 10);
        checkOutput("p19_ch1", hi[1], 5);
        checkOutput("p19_ticks", ticks, 1);

        // Two loads in one period: one ack, last value wins.
        cur_p = 9; cur_d = 32'hFF80_4000;
        applyStimulus(0, 1, 1);
        waitAck("back_to_p9_ack", 40);
        cur_d = 32'hFF80_4040;
        applyStimulus(0, 1, 1);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        cur_d = 32'hFF80_40C0;
        applyStimulus(0, 1, 1);
        window(12, hi, ticks, acks);
        checkOutput("double_load_acks", acks, 1);
        window(10, hi, ticks, acks);
        checkOutput("double_load_ch0", hi[0], 7);

        // Load coincident with the boundary while another load is pending.
        runToCnt(3);
        cur_d = 32'hFF80_4040;
        applyStimulus(0, 1, 1);
        runToCnt(9);
        cur_d = 32'hFF80_4080;
        applyStimulus(0, 1, 1);
        checkOutput("coinc_ack1", 32'(obs_ack), 32'd1);
        window(10, hi, ticks, acks);
        checkOutput("coinc_old_ch0", hi[0], 2);
        checkOutput("coinc_ack2", acks, 1);
        checkOutput("coinc_ack2_last", 32'(obs_ack), 32'd1);
        window(10, hi, ticks, acks);
        checkOutput("coinc_new_ch0", hi[0], 5);

        // P=0: tick constantly high, half duty gives th=0, full duty high.
        cur_p = 0; cur_d = 32'hFF00_0080;
        applyStimulus(0, 1, 1);
        waitAck("p0_ack", 30);
        window(6, hi, ticks, acks);
        checkOutput("p0_ticks", ticks, 6);
        checkOutput("p0_ch0", hi[0], 0);
        checkOutput("p0_ch3", hi[3], 6);

        // Reset at cnt=4 with a pending load: no ack, everything cleared.
        cur_p = 9; cur_d = 32'hFF80_4000;
        applyStimulus(0, 1, 1);
        waitAck("pre_rst_ack", 10);
        runToCnt(2);
        cur_d = 32'hFF80_40C0;
        applyStimulus(0, 1, 1);
        runToCnt(4);
        applyStimulus(1, 1, 0);
        checkOutput("midrst_pwm",  32'(obs_pwm), 32'd0);
        checkOutput("midrst_ack",  32'(obs_ack), 32'd0);
        checkOutput("midrst_tick", 32'(obs_tick), 32'd0);
        checkOutput("midrst_busy", 32'(obs_busy), 32'd0);
        cur_d = 32'hFF80_4000;
        applyStimulus(0, 0, 1);
        window(20, hi, ticks, acks);
        checkOutput("pending_discarded", acks, 0);

        // En=0 mid-run, then restart from cnt=0.
        runToCnt(5);
        applyStimulus(0, 0, 0);
        checkOutput("stop_pwm",  32'(obs_pwm), 32'd0);
        checkOutput("stop_busy", 32'(obs_busy), 32'd0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        window(10, hi, ticks, acks);
        checkOutput("restart_tick_last", 32'(obs_tick), 32'd1);
        checkOutput("restart_ticks", ticks, 1);
        checkOutput("restart_ch2", hi[2], 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Multi-channel, parametrised successor to the single-output PWM frequency divider. One shared period counter drives NUM_CH independent duty comparators. Period and duty updates are double-buffered and take effect only at a period boundary, so no runt or glitch pulses occur. The block sits between the register/control logic and the PWM pins.

Parameters:
CNT_W, 16, width of the period counter and period register
NUM_CH, 4, number of PWM output channels
DUTY_W, 8, duty resolution per channel (fraction of period, 2^DUTY_W steps)

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous, active-high reset
En  input  1  run enable
period_i  input  CNT_W  period value P; period length is P+1 Clk cycles
duty_i  input  NUM_CH*DUTY_W  packed duties; channel k uses bits [k*DUTY_W +: DUTY_W]
load_i  input  1  one-cycle request to capture period_i/duty_i
load_ack_o  output  1  one-cycle pulse when the captured values become active
period_tick_o  output  1  one-cycle pulse on the last count of each period
pwm_o  output  NUM_CH  PWM outputs
busy_o  output  1  high while state is RUN

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst). Every output is registered.
- Reset values: pwm_o=0, load_ack_o=0, period_tick_o=0, busy_o=0, cnt=0, active and pending registers=0, pending flag=0, state IDLE.
- FSM states:
  - IDLE: cnt=0, pwm_o=0.
  - RUN: counting.
- IDLE->RUN when En=1. RUN->IDLE when En=0. On that transition, cnt clears and pwm_o=0 on the next edge. Active registers are kept.
- Load in IDLE: load_i=1 copies inputs directly into the active registers. load_ack_o pulses on the next cycle.
- Load in RUN: load_i=1 copies inputs into the pending registers and sets the pending flag. A second load_i before the boundary overwrites the pending registers; only one ack is issued.
- Boundary: when cnt==P_active, cnt wraps to 0 and period_tick_o pulses. If the pending flag is set, pending is copied to active, the flag clears, and load_ack_o pulses in the same cycle as the wrap.
- Simultaneous load_i and boundary in the same cycle: the boundary applies the old pending data (if any). The new load becomes pending for the next boundary.
- Threshold per channel, computed when values become active: th_k = ((P+1) * duty_k) >> DUTY_W.
  - Intermediate width is CNT_W+1+DUTY_W; th_k is held in CNT_W+1 bits.
  - duty_k equal to all-ones forces a constant high (100%).
- Output rule: in RUN, pwm_o[k] is registered high when cnt < th_k, otherwise low. With one cycle of output latency, pwm_o[k] is high for exactly th_k cycles of each P+1-cycle period, starting the cycle after cnt=0.
- Boundary cases:
  - duty=0: constant low.
  - P=0: period is 1 cycle; every cycle is a boundary and period_tick_o stays high.
  - P=2^CNT_W-1: counter wraps with no overflow; th fits in CNT_W+1 bits.
- Rst asserted mid-period returns everything to the reset values on the next edge, including discarding a pending load without an ack.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- Defined: an extra input center_i (1 bit) is added.
  - With center_i=1, cnt counts up 0..P, then down P-1..1, giving a period of 2P cycles.
  - pwm_o[k] is high while cnt < th_k, which centres the pulses across channels.
  - The boundary (tick, load apply) occurs only at cnt=0 while counting up.
  - center_i is sampled only at the boundary.
- Undefined: no center_i port; edge-aligned behaviour only.

Test Plan:
- Rst, load P=9, duties {0x00,0x40,0x80,0xFF}, then En=1 -> per 10-cycle period: ch0 always 0, ch1 high 2 cycles, ch2 high 5 cycles, ch3 always 1; period_tick_o every 10 cycles.
- While running at P=9, load P=19 duty ch2=0x80 mid-period -> load_ack_o and the new 20-cycle period (10 cycles high) start exactly at the next wrap; no shortened pulse.
- Two load_i pulses in one period (duty 0x40, then 0xC0) -> single load_ack_o; ch0 applies 0xC0 (th=7 at P=9).
- load_i coincident with cnt==P while a load is pending -> old pending applied with ack now; new value applied with a second ack one period later.
- P=0, duty 0x80 -> pwm_o stays 0 (th=0), period_tick_o constantly 1; duty 0xFF -> constant 1.
- Rst pulse at cnt=4 with a load pending -> all outputs 0 next cycle, no ack; En=0 mid-run -> pwm_o=0, busy_o=0, and restart begins at cnt=0.
